// File: rtl/traffic_pkg.sv
// Shared state encoding and lamp indices for the crossroad controller and its display driver.
package traffic_pkg;

   typedef enum logic [1:0] {
      MG = 2'd0,
      MY = 2'd1,
      SG = 2'd2,
      SY = 2'd3
   } state_t;

   localparam logic [2:0] LAMP_MG    = 3'd0;
   localparam logic [2:0] LAMP_MY    = 3'd1;
   localparam logic [2:0] LAMP_SG    = 3'd2;
   localparam logic [2:0] LAMP_SY    = 3'd3;
   localparam logic [2:0] LAMP_NONE  = 3'd4;
   localparam logic [2:0] LAMP_BLANK = 3'd5;

   function automatic logic [2:0] main_lamp(input state_t s);
      case (s)
         MG:      main_lamp = LAMP_MG;
         MY:      main_lamp = LAMP_MY;
         default: main_lamp = LAMP_NONE;
      endcase
   endfunction

   function automatic logic [2:0] sub_lamp(input state_t s);
      case (s)
         SG:      sub_lamp = LAMP_SG;
         SY:      sub_lamp = LAMP_SY;
         default: sub_lamp = LAMP_NONE;
      endcase
   endfunction

endpackage

// File: rtl/traffic_light_ctrl_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
module tick_gen #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int             W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [W-1:0]   LAST = W'(TICK_DIV - 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || clr)
         r_cnt <= '0;
      else if (r_cnt == LAST)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + 1'b1;
   end

   assign tick = (r_cnt == LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Crossroad phase sequencer: MG->MY->SG->SY countdowns on a 1 s tick, plus off and maintenance modes.
module traffic_light_ctrl
   import traffic_pkg::*;
#(
   parameter int TICK_DIV = 100_000_000,
   parameter int MG_T     = 30,
   parameter int SG_T     = 20,
   parameter int Y_T      = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sw_off,
   input  logic       sw_maint,
   input  logic       hold,
   output logic [6:0] main_rest_time,
   output logic [6:0] sub_rest_time,
   output logic       dis,
   output logic       non,
   output logic [2:0] n1,
   output logic [2:0] n2
);

   localparam logic [6:0] MAIN_INIT = 7'(MG_T);
   localparam logic [6:0] SUB_INIT  = 7'(MG_T + Y_T);
   localparam logic [6:0] YEL       = 7'(Y_T);
   localparam logic [6:0] SUB_GRN   = 7'(SG_T);
   localparam logic [6:0] MAIN_RED  = 7'(SG_T + Y_T);

   state_t     r_state, w_state;
   logic [6:0] r_main, w_main, r_sub, w_sub;
   logic       r_blink, w_blink, r_dis, w_dis, r_non, w_non;
   logic [2:0] r_n1, w_n1, r_n2, w_n2;
   logic       w_tick;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (sw_off),
      .tick  (w_tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= MG;
         r_main  <= MAIN_INIT;
         r_sub   <= SUB_INIT;
         r_blink <= 1'b1;
         r_dis   <= 1'b0;
         r_non   <= 1'b0;
         r_n1    <= LAMP_MG;
         r_n2    <= LAMP_NONE;
      end else begin
         r_state <= w_state;
         r_main  <= w_main;
         r_sub   <= w_sub;
         r_blink <= w_blink;
         r_dis   <= w_dis;
         r_non   <= w_non;
         r_n1    <= w_n1;
         r_n2    <= w_n2;
      end
   end

   always_comb begin
      w_state = r_state;
      w_main  = r_main;
      w_sub   = r_sub;
      w_blink = r_blink;
      w_dis   = 1'b0;
      w_non   = 1'b0;
      w_n1    = LAMP_BLANK;
      w_n2    = LAMP_BLANK;
      if (sw_off) begin
         w_state = MG;
         w_main  = MAIN_INIT;
         w_sub   = SUB_INIT;
         w_blink = 1'b1;
         w_non   = 1'b1;
      end else if (sw_maint) begin
         w_state = MG;
         w_main  = MAIN_INIT;
         w_sub   = SUB_INIT;
         w_dis   = 1'b1;
         // r_dis low means this is the first maintenance cycle
         if (!r_dis)
            w_blink = 1'b1;
         else if (w_tick)
            w_blink = ~r_blink;
         w_n1 = w_blink ? LAMP_MY : LAMP_NONE;
         w_n2 = w_blink ? LAMP_SY : LAMP_NONE;
      end else begin
         if (w_tick && !hold) begin
            w_main = r_main - 7'd1;
            w_sub  = r_sub - 7'd1;
            case (r_state)
               MG: if (r_main == 7'd1) begin
                  w_state = MY;
                  w_main  = YEL;
               end
               MY: if (r_main == 7'd1) begin
                  w_state = SG;
                  w_main  = MAIN_RED;
                  w_sub   = SUB_GRN;
               end
               SG: if (r_sub == 7'd1) begin
                  w_state = SY;
                  w_sub   = YEL;
               end
               SY: if (r_sub == 7'd1) begin
                  w_state = MG;
                  w_main  = MAIN_INIT;
                  w_sub   = SUB_INIT;
               end
               default: w_state = MG;
            endcase
         end
         w_n1 = main_lamp(w_state);
         w_n2 = sub_lamp(w_state);
      end
   end

   assign main_rest_time = r_main;
   assign sub_rest_time  = r_sub;
   assign dis            = r_dis;
   assign non            = r_non;
   assign n1             = r_n1;
   assign n2             = r_n2;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench: a seconds-into-cycle model predicts every registered output, cycle by cycle.
module tb_traffic_light_ctrl;

   localparam int D   = 4;
   localparam int MGT = 5;
   localparam int SGT = 3;
   localparam int YT  = 2;
   localparam int CYC = MGT + SGT + 2 * YT;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0, sw_off = 1'b0, sw_maint = 1'b0, hold = 1'b0;
   logic [6:0] main_rest_time, sub_rest_time;
   logic       dis, non;
   logic [2:0] n1, n2;

   traffic_light_ctrl #(.TICK_DIV(D), .MG_T(MGT), .SG_T(SGT), .Y_T(YT)) dut (
      .clk(clk), .rst_n(rst_n), .sw_off(sw_off), .sw_maint(sw_maint), .hold(hold),
      .main_rest_time(main_rest_time), .sub_rest_time(sub_rest_time),
      .dis(dis), .non(non), .n1(n1), .n2(n2)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [6:0] main;
      logic [6:0] sub;
      logic       dis;
      logic       non;
      logic [2:0] n1;
      logic [2:0] n2;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0, n_pass = 0, cyc = 0;

   // reference model: prescaler phase, seconds elapsed in the 12 s cycle, mode (0 run, 1 maint, 2 off)
   int m_pre = 0, m_sec = 0, m_mode = 0;
   bit m_blink = 1'b1;

   function automatic exp_t predict();
      exp_t e;
      int   s;
      s      = m_sec;
      e.main = 7'(MGT);
      e.sub  = 7'(MGT + YT);
      e.dis  = 1'b0;
      e.non  = 1'b0;
      if (m_mode == 2) begin
         e.non = 1'b1; e.n1 = 3'd5; e.n2 = 3'd5;
      end else if (m_mode == 1) begin
         e.dis = 1'b1;
         e.n1  = m_blink ? 3'd1 : 3'd4;
         e.n2  = m_blink ? 3'd3 : 3'd4;
      end else if (s < MGT) begin
         e.main = 7'(MGT - s); e.sub = 7'(MGT + YT - s); e.n1 = 3'd0; e.n2 = 3'd4;
      end else if (s < MGT + YT) begin
         e.main = 7'(MGT + YT - s); e.sub = 7'(MGT + YT - s); e.n1 = 3'd1; e.n2 = 3'd4;
      end else if (s < MGT + YT + SGT) begin
         e.main = 7'(CYC - s); e.sub = 7'(MGT + YT + SGT - s); e.n1 = 3'd4; e.n2 = 3'd2;
      end else begin
         e.main = 7'(CYC - s); e.sub = 7'(CYC - s); e.n1 = 3'd4; e.n2 = 3'd3;
      end
      return e;
   endfunction

   task automatic step(input bit r, input bit off, input bit mnt, input bit hd);
      bit tk;
      @(negedge clk);
      rst_n = r; sw_off = off; sw_maint = mnt; hold = hd;
      if (!r) begin
         m_pre = 0; m_sec = 0; m_blink = 1'b1; m_mode = 0;
      end else if (off) begin
         m_pre = 0; m_sec = 0; m_blink = 1'b1; m_mode = 2;
      end else begin
         tk    = (m_pre == D - 1);
         m_pre = (m_pre + 1) % D;
         if (mnt) begin
            m_sec   = 0;
            m_blink = (m_mode != 1) ? 1'b1 : (tk ? ~m_blink : m_blink);
            m_mode  = 1;
         end else begin
            if (tk && !hd) m_sec = (m_sec + 1) % CYC;
            m_mode = 0;
         end
      end
      q.push_back(predict());
   endtask

   // monitor: every edge presents a fresh registered output word
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (q.size() != 0) begin
            e = q.pop_front();
            n_chk++;
            if (main_rest_time === e.main && sub_rest_time === e.sub && dis === e.dis &&
                non === e.non && n1 === e.n1 && n2 === e.n2)
               n_pass++;
            else
               $display("FAIL outputs cyc=%0d got main/sub=%0d/%0d dis/non=%0d/%0d n1/n2=%0d/%0d want %0d/%0d %0d/%0d %0d/%0d",
                        cyc, main_rest_time, sub_rest_time, dis, non, n1, n2,
                        e.main, e.sub, e.dis, e.non, e.n1, e.n2);
         end
      end
   end

   initial begin
      exp_t cur;
      bit   r_off, r_mnt, r_hd;
      int   guard;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      // two full cycles plus margin: phase boundaries and wrap
      for (int i = 0; i < 2 * CYC * D + 6; i++) step(1, 0, 0, 0);
      // freeze for 10 ticks at main=3
      guard = 0;
      cur = predict();
      while (!(cur.main == 7'd3 && m_mode == 0 && cur.n1 == 3'd0) && guard < 200) begin
         step(1, 0, 0, 0); cur = predict(); guard++;
      end
      for (int i = 0; i < 10 * D; i++) step(1, 0, 0, 1);
      for (int i = 0; i < 2 * D; i++) step(1, 0, 0, 0);
      // maintenance blink and exit
      for (int i = 0; i < 6 * D + 1; i++) step(1, 0, 1, 0);
      for (int i = 0; i < 3 * D; i++) step(1, 0, 0, 0);
      // off overrides maintenance; prescaler restarts on exit
      for (int i = 0; i < 5 * D + 3; i++) step(1, 1, 1, 0);
      for (int i = 0; i < 3 * D; i++) step(1, 0, 0, 0);
      // one-cycle reset mid-SG with sub=2
      guard = 0;
      while (!(m_sec == MGT + YT + SGT - 2 && m_mode == 0) && guard < 200) begin
         step(1, 0, 0, 0); guard++;
      end
      step(0, 0, 0, 0);
      for (int i = 0; i < 3 * D; i++) step(1, 0, 0, 0);
      // reset landing on a tick cycle
      guard = 0;
      while (m_pre != D - 1 && guard < 10) begin
         step(1, 0, 0, 0); guard++;
      end
      step(0, 0, 0, 0);
      for (int i = 0; i < 2 * D; i++) step(1, 0, 0, 0);
      // randomized mode traffic with persistent switches
      r_off = 0; r_mnt = 0; r_hd = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) < 2) r_off = ~r_off;
         if ($urandom_range(0, 99) < 3) r_mnt = ~r_mnt;
         if ($urandom_range(0, 99) < 5) r_hd  = ~r_hd;
         step(($urandom_range(0, 199) != 0), r_off, r_mnt, r_hd);
      end
      step(1, 0, 0, 0);
      @(posedge clk);
      #2;
      n_chk++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL drain left=%0d want 0", q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
